hs_multi_chan_ctrl: RTL and testbench

//  Single-clock, N-channel successor of the req/valid/done handshake controller.

---
 rtl/hs_multi_chan_ctrl_pkg.sv | 16 +
 rtl/hs_multi_chan_ctrl_if.sv | 29 ++
 rtl/hs_multi_chan_ctrl_rr_arbiter.sv | 34 +++
 rtl/hs_multi_chan_ctrl.sv | 105 ++++++++++
 tb/tb_hs_multi_chan_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hs_multi_chan_ctrl_pkg.sv
// hs_multi_chan_ctrl_pkg: shared FSM state encoding and sizing helpers for the handshake blocks
//   HS_IDLE   : no transaction in flight, arbitration enabled
//   HS_ACTIVE : one payload presented to the consumer
package hs_multi_chan_ctrl_pkg;

    typedef enum logic [0:0] {
        HS_IDLE   = 1'b0,
        HS_ACTIVE = 1'b1
    } hs_state_e;

    // Width of a counter that must reach timeout-1; never narrower than one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/hs_multi_chan_ctrl_if.sv
// hs_multi_chan_ctrl_if: source-side and consumer-side signals of the multi-channel controller
//   ch_req/ch_data/dst_done           : driven by the environment (master)
//   ch_ready/ch_err/dst_valid/dst_data/dst_ch/busy : driven by the controller (slave)
interface hs_multi_chan_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_ready;
    logic [NUM_CH-1:0]        ch_err;
    logic                     dst_valid;
    logic [DATA_W-1:0]        dst_data;
    logic [CH_W-1:0]          dst_ch;
    logic                     dst_done;
    logic                     busy;

    modport master (
        output ch_req, ch_data, dst_done,
        input  ch_ready, ch_err, dst_valid, dst_data, dst_ch, busy
    );

    modport slave (
        input  ch_req, ch_data, dst_done,
        output ch_ready, ch_err, dst_valid, dst_data, dst_ch, busy
    );
endinterface

// File: rtl/hs_multi_chan_ctrl_rr_arbiter.sv
// hs_multi_chan_ctrl_rr_arbiter: combinational round-robin pick, search starts just after ptr_i
//   req_i : request vector        ptr_i : last served index
//   gnt_o : one-hot grant         idx_o : binary grant index   any_o : some request present
module hs_multi_chan_ctrl_rr_arbiter #(
    parameter int N    = 4,
    parameter int CH_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [CH_W-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [CH_W-1:0] idx_o,
    output logic            any_o
);
    logic [CH_W-1:0] c;
    logic            found;

    assign any_o = |req_i;

    // Offsets 1..N visit every channel once, ending on ptr_i itself (lowest priority).
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        c     = '0;
        for (int i = 1; i <= N; i++) begin
            c = CH_W'((int'(ptr_i) + i) % N);
            if (!found && req_i[c]) begin
                found    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = c;
            end
        end
    end
endmodule

// File: rtl/hs_multi_chan_ctrl.sv
// hs_multi_chan_ctrl: round-robin N-channel req/valid/done controller with per-transaction timeout
//   clk, rst : single clock, synchronous active-high reset
//   hs       : slave side of hs_multi_chan_ctrl_if (source requests/payloads, consumer port, busy)
module hs_multi_chan_ctrl
    import hs_multi_chan_ctrl_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 rst,
    hs_multi_chan_ctrl_if.slave hs
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam bit TO_EN = TIMEOUT != 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    hs_state_e         state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] ready_q, ready_d;
    logic [NUM_CH-1:0] err_q, err_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CH_W-1:0]   ch_q, ch_d;

    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   idx;
    logic              any;

    // The in-flight channel has ready low, so its held request is masked here.
    hs_multi_chan_ctrl_rr_arbiter #(.N(NUM_CH), .CH_W(CH_W)) u_arb (
        .req_i (hs.ch_req & ready_q),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (idx),
        .any_o (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HS_IDLE;
            ptr_q   <= CH_W'(NUM_CH - 1);
            cnt_q   <= '0;
            ready_q <= '1;
            err_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        err_d   = '0;
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        if (state_q == HS_IDLE) begin
            if (any) begin
                state_d = HS_ACTIVE;
                valid_d = 1'b1;
                data_d  = hs.ch_data[idx*DATA_W +: DATA_W];
                ch_d    = idx;
                ready_d = ready_q & ~gnt;
                cnt_d   = '0;
            end
        end else if (hs.dst_done) begin
            // Completion takes precedence over a timeout landing in the same cycle.
            state_d       = HS_IDLE;
            valid_d       = 1'b0;
            ready_d[ch_q] = 1'b1;
            ptr_d         = ch_q;
        end else if (TO_EN && cnt_q == TO_LAST) begin
            state_d       = HS_IDLE;
            valid_d       = 1'b0;
            ready_d[ch_q] = 1'b1;
            err_d[ch_q]   = 1'b1;
            ptr_d         = ch_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign hs.ch_ready  = ready_q;
    assign hs.ch_err    = err_q;
    assign hs.dst_valid = valid_q;
    assign hs.dst_data  = data_q;
    assign hs.dst_ch    = ch_q;
    assign hs.busy      = state_q != HS_IDLE;
endmodule

// File: tb/tb_hs_multi_chan_ctrl.sv
// tb_hs_multi_chan_ctrl: directed and randomized checks of hs_multi_chan_ctrl against a transaction-level model
module tb_hs_multi_chan_ctrl;
    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int TO  = 8;

    logic clk;
    logic rst;

    hs_multi_chan_ctrl_if #(.NUM_CH(NCH), .DATA_W(DW)) u8_if ();
    hs_multi_chan_ctrl_if #(.NUM_CH(NCH), .DATA_W(DW)) u0_if ();

    hs_multi_chan_ctrl #(.NUM_CH(NCH), .DATA_W(DW), .TIMEOUT(TO)) dut8 (
        .clk (clk),
        .rst (rst),
        .hs  (u8_if)
    );

    hs_multi_chan_ctrl #(.NUM_CH(NCH), .DATA_W(DW), .TIMEOUT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .hs  (u0_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Model: one outstanding transaction, age = cycles dst_valid has been shown so far.
    bit [NCH-1:0] m_ready;
    bit [NCH-1:0] m_err;
    bit           m_valid;
    bit           m_busy;
    bit [DW-1:0]  m_data;
    int           m_ch;
    int           m_last;
    int           m_age;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit found;
        int c;
        if (rst) begin
            m_ready = '1;
            m_err   = '0;
            m_valid = 0;
            m_busy  = 0;
            m_data  = '0;
            m_ch    = 0;
            m_last  = NCH - 1;
            m_age   = 0;
        end else begin
            m_err = '0;
            if (!m_busy) begin
                found = 0;
                for (int k = 1; k <= NCH; k++) begin
                    c = (m_last + k) % NCH;
                    if (!found && u8_if.ch_req[c] && m_ready[c]) begin
                        found      = 1;
                        m_busy     = 1;
                        m_valid    = 1;
                        m_ch       = c;
                        m_data     = u8_if.ch_data[c*DW +: DW];
                        m_ready[c] = 0;
                        m_age      = 1;
                    end
                end
            end else if (u8_if.dst_done || m_age == TO) begin
                if (!u8_if.dst_done) m_err[m_ch] = 1;
                m_busy        = 0;
                m_valid       = 0;
                m_ready[m_ch] = 1;
                m_last        = m_ch;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic check_all();
        chk("valid", 64'(u8_if.dst_valid), 64'(m_valid));
        chk("data", 64'(u8_if.dst_data), 64'(m_data));
        chk("ch", 64'(u8_if.dst_ch), 64'(m_ch));
        chk("ready", 64'(u8_if.ch_ready), 64'(m_ready));
        chk("err", 64'(u8_if.ch_err), 64'(m_err));
        chk("busy", 64'(u8_if.busy), 64'(m_busy));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    int order[$];
    int n;
    logic [NCH-1:0] nreq;

    initial begin
        rst            = 1'b1;
        u8_if.ch_req   = '0;
        u8_if.ch_data  = '0;
        u8_if.dst_done = 1'b0;
        u0_if.ch_req   = '0;
        u0_if.ch_data  = '0;
        u0_if.dst_done = 1'b0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_ready", 64'(u8_if.ch_ready), 64'hF);
        chk("rst_valid", 64'(u8_if.dst_valid), 64'h0);
        chk("rst_data", 64'(u8_if.dst_data), 64'h0);
        chk("rst_busy", 64'(u8_if.busy), 64'h0);
        rst = 1'b0;

        // Reset in the middle of a transaction
        u8_if.ch_req  = 4'b1000;
        u8_if.ch_data = {32'h3333_0003, 96'h0};
        tick();
        chk("t1_busy", 64'(u8_if.busy), 64'h1);
        rst          = 1'b1;
        u8_if.ch_req = '0;
        tick();
        tick();
        chk("t1_ready", 64'(u8_if.ch_ready), 64'hF);
        chk("t1_valid", 64'(u8_if.dst_valid), 64'h0);
        chk("t1_busy0", 64'(u8_if.busy), 64'h0);
        rst = 1'b0;

        // Single request on channel 2
        u8_if.ch_req  = 4'b0100;
        u8_if.ch_data = {32'h0, 32'hA5A5_0002, 64'h0};
        tick();
        chk("t2_valid", 64'(u8_if.dst_valid), 64'h1);
        chk("t2_ch", 64'(u8_if.dst_ch), 64'h2);
        chk("t2_data", 64'(u8_if.dst_data), 64'hA5A5_0002);
        chk("t2_ready", 64'(u8_if.ch_ready), 64'b1011);
        u8_if.ch_req = '0;
        tick();
        tick();
        u8_if.dst_done = 1'b1;
        tick();
        u8_if.dst_done = 1'b0;
        chk("t2_valid0", 64'(u8_if.dst_valid), 64'h0);
        chk("t2_ready1", 64'(u8_if.ch_ready), 64'hF);
        chk("t2_hold", 64'(u8_if.dst_data), 64'hA5A5_0002);

        // All channels requesting, consumer always done
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        u8_if.ch_req   = 4'b1111;
        u8_if.ch_data  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        u8_if.dst_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_pulse", 64'(u8_if.dst_valid), 64'((i % 2) == 0));
            if (u8_if.dst_valid) order.push_back(int'(u8_if.dst_ch));
        end
        chk("t3_count", 64'(order.size()), 64'd5);
        for (int i = 0; i < order.size() && i < 5; i++) chk("t3_order", 64'(order[i]), 64'(i % NCH));
        u8_if.ch_req   = '0;
        u8_if.dst_done = 1'b0;
        tick();
        tick();

        // Timeout on channel 1
        u8_if.ch_req  = 4'b0010;
        u8_if.ch_data = {64'h0, 32'h1111_0001, 32'h0};
        tick();
        u8_if.ch_req = '0;
        n = u8_if.dst_valid ? 1 : 0;
        while (u8_if.dst_valid && n < 20) begin
            tick();
            if (u8_if.dst_valid) n++;
        end
        chk("t4_len", 64'(n), 64'd8);
        chk("t4_err", 64'(u8_if.ch_err), 64'b0010);
        chk("t4_ready", 64'(u8_if.ch_ready), 64'hF);
        tick();
        chk("t4_err_pulse", 64'(u8_if.ch_err), 64'h0);

        // Completion in the final allowed cycle beats the timeout
        u8_if.ch_req = 4'b0010;
        tick();
        u8_if.ch_req = '0;
        repeat (7) tick();
        chk("t5_still", 64'(u8_if.dst_valid), 64'h1);
        u8_if.dst_done = 1'b1;
        tick();
        u8_if.dst_done = 1'b0;
        chk("t5_valid", 64'(u8_if.dst_valid), 64'h0);
        chk("t5_err", 64'(u8_if.ch_err), 64'h0);
        chk("t5_ready", 64'(u8_if.ch_ready), 64'hF);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < NCH; c++) begin
                nreq[c] = ($urandom_range(0, 3) == 0) ? ~u8_if.ch_req[c] : u8_if.ch_req[c];
                if (!u8_if.ch_req[c]) u8_if.ch_data[c*DW +: DW] = $urandom;
            end
            u8_if.ch_req   = nreq;
            u8_if.dst_done = $urandom_range(0, 3) == 0;
            rst            = $urandom_range(0, 99) == 0;
            tick();
        end
        rst            = 1'b0;
        u8_if.ch_req   = '0;
        u8_if.dst_done = 1'b0;

        // Timeout disabled: valid never drops on its own
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        u0_if.ch_req  = 4'b1000;
        u0_if.ch_data = {32'hC0DE_0003, 96'h0};
        tick();
        u0_if.ch_req = '0;
        chk("t6_valid", 64'(u0_if.dst_valid), 64'h1);
        chk("t6_ch", 64'(u0_if.dst_ch), 64'h3);
        for (int i = 0; i < 1000; i++) begin
            tick();
            chk("t6_hold", 64'(u0_if.dst_valid), 64'h1);
            chk("t6_noerr", 64'(u0_if.ch_err), 64'h0);
        end
        u0_if.dst_done = 1'b1;
        tick();
        chk("t6_done", 64'(u0_if.dst_valid), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_idle_valid", 64'(u0_if.dst_valid), 64'h0);
            chk("t6_idle_busy", 64'(u0_if.busy), 64'h0);
            chk("t6_idle_ready", 64'(u0_if.ch_ready), 64'hF);
            chk("t6_idle_data", 64'(u0_if.dst_data), 64'hC0DE_0003);
        end
        u0_if.dst_done = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
